// File: rtl/lsu_bridge.sv
// Load/store bridge: byte-addressed core requests to a word-wide bus, with strobe generation,
// two-beat splitting of word-crossing accesses and aligned, extended load return.
module lsu_bridge #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        split_q;
    logic [3:0]  hi_strb_q;
    logic [31:0] hi_data_q;
    logic [31:0] lo_q;

    logic [2:0]  req_nbytes;
    logic [3:0]  req_mask;
    logic [1:0]  req_off;
    logic        req_split;
    logic        req_illegal;
    logic [7:0]  req_wide_strb;
    logic [63:0] req_wide_data;
    logic [63:0] load_raw;
    logic [31:0] load_data;

    function automatic logic [31:0] extract(input logic [63:0] raw, input logic [1:0] off,
                                            input logic [2:0] size);
        logic [31:0] sh;
        sh = 32'(raw >> {off, 3'b000});
        case (size)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return {24'b0, sh[7:0]};
            3'd5:    return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        req_off = req_addr[1:0];
        case (req_size[1:0])
            2'd0: begin req_nbytes = 3'd1; req_mask = 4'b0001; end
            2'd1: begin req_nbytes = 3'd2; req_mask = 4'b0011; end
            default: begin req_nbytes = 3'd4; req_mask = 4'b1111; end
        endcase
        req_split     = ({1'b0, req_off} + req_nbytes) > 3'd4;
        req_illegal   = (req_size[1:0] == 2'b11) || (req_size[2] && req_size[1]);
        req_wide_strb = {4'b0000, req_mask} << req_off;
        req_wide_data = {32'b0, req_wdata} << {req_off, 3'b000};
    end

    // The final beat's data is still on the bus when the response is formed.
    always_comb begin
        load_raw  = (state == StAcc1) ? {bus_rdata, lo_q} : {32'b0, bus_rdata};
        load_data = extract(load_raw, off_q, size_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'b0;
            bus_wstrb <= 4'b0;
            bus_wdata <= 32'b0;
            we_q      <= 1'b0;
            off_q     <= 2'b0;
            size_q    <= 3'b0;
            split_q   <= 1'b0;
            hi_strb_q <= 4'b0;
            hi_data_q <= 32'b0;
            lo_q      <= 32'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        off_q     <= req_off;
                        size_q    <= req_size;
                        split_q   <= req_split;
                        hi_strb_q <= req_we ? req_wide_strb[7:4] : 4'b0;
                        hi_data_q <= req_wide_data[63:32];
                        if (req_illegal || (req_split && !ALLOW_MISALIGNED)) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'b0;
                        end else begin
                            state     <= StAcc0;
                            bus_valid <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_wstrb <= req_we ? req_wide_strb[3:0] : 4'b0;
                            bus_wdata <= req_wide_data[31:0];
                        end
                    end
                end
                StAcc0, StAcc1: begin
                    if (bus_ready) begin
                        lo_q <= bus_rdata;
                        if (state == StAcc0 && split_q) begin
                            state     <= StAcc1;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_wstrb <= hi_strb_q;
                            bus_wdata <= hi_data_q;
                        end else begin
                            state     <= StResp;
                            bus_valid <= 1'b0;
                            bus_we    <= 1'b0;
                            bus_wstrb <= 4'b0;
                            bus_wdata <= 32'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= we_q ? 32'b0 : load_data;
                        end
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// Bench for lsu_bridge: directed and random accesses checked against a byte-level memory model,
// with a misaligned-capable instance and a misaligned-rejecting instance.
module tb_lsu_bridge;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    logic        clk, rst;
    logic        req_valid, req_valid_na, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;

    logic        req_ready, rsp_valid, rsp_err, bus_valid, bus_ready, bus_we;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    logic        na_req_ready, na_rsp_valid, na_rsp_err, na_bus_valid, na_bus_ready, na_bus_we;
    logic [31:0] na_rsp_rdata, na_bus_addr, na_bus_wdata, na_bus_rdata;
    logic [3:0]  na_bus_wstrb;

    int total = 0;
    int bad = 0;
    int fixed_waits = 0;
    bit rand_waits = 0;
    int na_beats = 0;
    beat_t beat_q[$];
    logic [31:0] mem_ovr[logic [31:0]];

    lsu_bridge #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    lsu_bridge #(.ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_ready(na_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(na_rsp_valid), .rsp_err(na_rsp_err), .rsp_rdata(na_rsp_rdata),
        .bus_valid(na_bus_valid), .bus_ready(na_bus_ready), .bus_we(na_bus_we),
        .bus_addr(na_bus_addr), .bus_wstrb(na_bus_wstrb), .bus_wdata(na_bus_wdata),
        .bus_rdata(na_bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A3C96E1;
    endfunction

    // Bus slave for the main instance: programmable wait states, records each accepted beat.
    initial begin
        int wait_cnt, target;
        bit waiting;
        beat_t b, s;
        bus_ready = 1'b0;
        bus_rdata = 32'b0;
        wait_cnt = 0;
        target = 0;
        waiting = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_valid) begin
                if (!waiting) begin
                    target = rand_waits ? int'($urandom_range(0, 2)) : fixed_waits;
                    wait_cnt = 0;
                end else begin
                    check_eq("stable_addr", bus_addr, s.addr);
                    check_eq("stable_strb", 32'(bus_wstrb), 32'(s.strb));
                    check_eq("stable_wdata", bus_wdata, s.data);
                    check_eq("stable_we", 32'(bus_we), 32'(s.we));
                end
                b.addr = bus_addr;
                b.we = bus_we;
                b.strb = bus_wstrb;
                b.data = bus_wdata;
                if (wait_cnt >= target) begin
                    bus_ready = 1'b1;
                    bus_rdata = mem_word(bus_addr);
                    beat_q.push_back(b);
                    waiting = 1'b0;
                end else begin
                    bus_ready = 1'b0;
                    wait_cnt++;
                    waiting = 1'b1;
                    s = b;
                end
            end else begin
                bus_ready = 1'b0;
                waiting = 1'b0;
            end
        end
    end

    initial begin
        na_bus_ready = 1'b0;
        na_bus_rdata = 32'b0;
        forever begin
            @(negedge clk);
            na_bus_ready = na_bus_valid;
            if (na_bus_valid) begin
                na_bus_rdata = mem_word(na_bus_addr);
                na_beats++;
            end
        end
    end

    // Issue one request from a negedge and check it against the byte-level model.
    task automatic do_req(input bit use_na, input bit we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] e_addr[2];
        logic [3:0]  e_strb[2];
        logic [31:0] e_data[2];
        logic [31:0] val, exp_rd, a, w, m;
        logic [7:0]  bt;
        logic        exp_err, rv;
        int ne, nb, lane, lat, exp_lat;

        nb = 0;
        exp_err = 1'b0;
        case (size)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    exp_err = 1'b1;
        endcase
        if (!exp_err && use_na && (int'(addr[1:0]) + nb > 4)) exp_err = 1'b1;
        ne = 0;
        val = 32'b0;
        if (!exp_err) begin
            for (int i = 0; i < nb; i++) begin
                a = addr + 32'(i);
                w = {a[31:2], 2'b00};
                lane = int'(a[1:0]);
                if (ne == 0 || e_addr[ne-1] != w) begin
                    e_addr[ne] = w;
                    e_strb[ne] = 4'b0;
                    e_data[ne] = 32'b0;
                    ne++;
                end
                if (we) begin
                    e_strb[ne-1][lane] = 1'b1;
                    e_data[ne-1][8*lane +: 8] = wdata[8*i +: 8];
                end
                bt = 8'(mem_word(w) >> (8 * lane));
                val[8*i +: 8] = bt;
            end
        end
        exp_rd = 32'b0;
        if (!we && !exp_err) begin
            case (size)
                3'd0:    exp_rd = {{24{val[7]}}, val[7:0]};
                3'd1:    exp_rd = {{16{val[15]}}, val[15:0]};
                3'd4:    exp_rd = {24'b0, val[7:0]};
                3'd5:    exp_rd = {16'b0, val[15:0]};
                default: exp_rd = val;
            endcase
        end
        exp_lat = exp_err ? 1 : 1 + ne * (1 + (use_na ? 0 : fixed_waits));

        beat_q.delete();
        na_beats = 0;
        req_we = we;
        req_addr = addr;
        req_size = size;
        req_wdata = wdata;
        if (use_na) req_valid_na = 1'b1;
        else req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_valid_na = 1'b0;
        req_addr = $urandom;
        req_wdata = $urandom;
        req_size = 3'($urandom);
        req_we = 1'($urandom);

        lat = 1;
        forever begin
            rv = use_na ? na_rsp_valid : rsp_valid;
            if (rv || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_valid", 32'(rv), 32'd1);
        if (use_na || !rand_waits) check_eq("latency", lat, exp_lat);
        check_eq("rsp_err", 32'(use_na ? na_rsp_err : rsp_err), 32'(exp_err));
        check_eq("rsp_rdata", use_na ? na_rsp_rdata : rsp_rdata, exp_rd);
        if (use_na) begin
            check_eq("na_beats", na_beats, ne);
        end else begin
            check_eq("beat_count", beat_q.size(), ne);
            for (int i = 0; i < ne && i < beat_q.size(); i++) begin
                check_eq("beat_addr", beat_q[i].addr, e_addr[i]);
                check_eq("beat_we", 32'(beat_q[i].we), 32'(we));
                check_eq("beat_strb", 32'(beat_q[i].strb), 32'(e_strb[i]));
                if (we) begin
                    m = {{8{e_strb[i][3]}}, {8{e_strb[i][2]}}, {8{e_strb[i][1]}}, {8{e_strb[i][0]}}};
                    check_eq("beat_wdata", beat_q[i].data & m, e_data[i]);
                end
            end
        end
        @(negedge clk);
        check_eq("rsp_pulse", 32'(use_na ? na_rsp_valid : rsp_valid), 32'd0);
        check_eq("ready_again", 32'(use_na ? na_req_ready : req_ready), 32'd1);
        check_eq("rsp_hold", use_na ? na_rsp_rdata : rsp_rdata, exp_rd);
    endtask

    initial begin
        logic [2:0] sizes[14];
        bit found;
        int nrsp;
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
        rst = 1'b1;
        req_valid = 1'b0;
        req_valid_na = 1'b0;
        req_we = 1'b0;
        req_addr = 32'b0;
        req_size = 3'b0;
        req_wdata = 32'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_bus_valid", 32'(bus_valid), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check_eq("rst_na_ready", 32'(na_req_ready), 32'd1);
        rst = 1'b0;

        mem_ovr[32'h100] = 32'hDEADBEEF;
        do_req(1'b0, 1'b0, 32'h100, 3'd2, 32'h0);
        check_eq("lw_value", rsp_rdata, 32'hDEADBEEF);
        mem_ovr[32'h100] = 32'h80FFFFFF;
        do_req(1'b0, 1'b0, 32'h103, 3'd0, 32'h0);
        check_eq("lb_value", rsp_rdata, 32'hFFFFFF80);
        do_req(1'b0, 1'b0, 32'h103, 3'd4, 32'h0);
        do_req(1'b0, 1'b0, 32'h102, 3'd5, 32'h0);
        do_req(1'b0, 1'b1, 32'h202, 3'd1, 32'h1234ABCD);

        fixed_waits = 1;
        mem_ovr[32'h1004] = 32'h44332211;
        mem_ovr[32'h1008] = 32'h88776655;
        do_req(1'b0, 1'b0, 32'h1006, 3'd2, 32'h0);
        check_eq("split_lw_value", rsp_rdata, 32'h66554433);
        fixed_waits = 0;
        do_req(1'b0, 1'b1, 32'h3003, 3'd2, 32'hAABBCCDD);
        do_req(1'b0, 1'b0, 32'hFFFFFFFE, 3'd2, 32'h0);
        do_req(1'b0, 1'b0, 32'h0, 3'd3, 32'h0);

        do_req(1'b1, 1'b0, 32'h3, 3'd1, 32'h0);
        do_req(1'b1, 1'b0, 32'h0, 3'd3, 32'h0);
        do_req(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
        do_req(1'b1, 1'b1, 32'h3003, 3'd2, 32'h11223344);

        // Reset while the second beat of a split store is waiting.
        fixed_waits = 3;
        beat_q.delete();
        req_we = 1'b1;
        req_addr = 32'h3003;
        req_size = 3'd2;
        req_wdata = 32'hAABBCCDD;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus_valid && bus_addr == 32'h3004) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("reach_acc1", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_bus_valid", 32'(bus_valid), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        nrsp = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check_eq("abort_no_rsp", nrsp, 0);
        check_eq("abort_beat0_committed", beat_q.size(), 1);
        fixed_waits = 0;

        rand_waits = 1'b1;
        mem_ovr.delete();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFFC | {30'b0, addr[1:0]};
            do_req($urandom_range(0, 3) == 0, 1'($urandom), addr,
                   sizes[$urandom_range(0, 13)], $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
